datapath_sequencer: RTL and testbench

- Multi-cycle control unit for the register-file/ALU/RAM datapath: 32x64 register file, ALU with 5-bit function select and 4 status bits, 256x64 RAM.
- Fetches 32-bit instructions from a synchronous program ROM.
- Decodes each instruction and drives every datapath control input cycle by cycle.
- Maintains the program counter, resolves conditional branches from ALU status bits, and reports completion on HALT.

---
 rtl/seq_pkg.sv | 64 ++++++
 rtl/instr_decoder.sv | 70 +++++++
 rtl/datapath_sequencer.sv | 135 +++++++++++++
 tb/tb_datapath_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, FSM states,
// instruction field positions and the datapath control word.
package seq_pkg;

  // Opcodes; every value not listed here executes as a no-op.
  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_LD   = 4'd1;
  localparam logic [3:0] OP_ST   = 4'd2;
  localparam logic [3:0] OP_BRZ  = 4'd3;
  localparam logic [3:0] OP_JMP  = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Instruction field bit positions. cin and tgt overlap on bit 7:
  // memory/ALU instructions read cin, branches read tgt.
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 23;
  localparam int RA_MSB  = 22;
  localparam int RA_LSB  = 18;
  localparam int RB_MSB  = 17;
  localparam int RB_LSB  = 13;
  localparam int FS_MSB  = 12;
  localparam int FS_LSB  = 8;
  localparam int CIN_BIT = 7;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  // What the current instruction asks the FSM to do after this state.
  typedef enum logic [2:0] {
    CLS_FETCH,
    CLS_MEM,
    CLS_WB,
    CLS_BRZ,
    CLS_JMP,
    CLS_HALT
  } nextClass_t;

  typedef struct packed {
    logic [4:0] readA;
    logic [4:0] readB;
    logic [4:0] writeReg;
    logic       write;
    logic [4:0] functionsel;
    logic       ALUcarry;
    logic       RAMwrite;
    logic       muxSelect;
  } ctrlWord_t;

  // Only instructions that actually run the ALU on data forward cin.
  function automatic logic usesCarry(input logic [3:0] op);
    return (op == OP_ALU) || (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decoder: turns the latched instruction plus the current
// FSM state into datapath controls and the follow-on state class.
module instr_decoder
  import seq_pkg::*;
(
  input  logic [31:0] ir,
  input  state_t      state,
  output ctrlWord_t   ctrl,
  output nextClass_t  nextClass,
  output logic [7:0]  tgt
);

  logic [3:0] op;
  logic [4:0] rd;
  logic [4:0] ra;
  logic [4:0] rb;
  logic [4:0] fs;
  logic       cin;

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign ra  = ir[RA_MSB:RA_LSB];
  assign rb  = ir[RB_MSB:RB_LSB];
  assign fs  = ir[FS_MSB:FS_LSB];
  assign cin = ir[CIN_BIT];
  assign tgt = ir[TGT_MSB:TGT_LSB];

  // Control word and next-state class; everything idles at zero outside
  // the execute/memory/write-back states.
  always_comb begin
    ctrl      = '0;
    nextClass = CLS_FETCH;

    // Operand selects appear in EXEC and stay put through MEM and WB so
    // ALUout (RAM address / write-back data) is stable for the whole op.
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      ctrl.readA       = ra;
      ctrl.readB       = rb;
      ctrl.functionsel = fs;
      ctrl.ALUcarry    = usesCarry(op) ? cin : 1'b0;
    end

    case (state)
      S_EXEC: begin
        case (op)
          OP_ALU:       nextClass = CLS_WB;
          OP_LD, OP_ST: nextClass = CLS_MEM;
          OP_BRZ:       nextClass = CLS_BRZ;
          OP_JMP:       nextClass = CLS_JMP;
          OP_HALT:      nextClass = CLS_HALT;
          default:      nextClass = CLS_FETCH;
        endcase
      end
      S_MEM: begin
        ctrl.RAMwrite = (op == OP_ST);
        nextClass     = (op == OP_LD) ? CLS_WB : CLS_FETCH;
      end
      S_WB: begin
        ctrl.write     = 1'b1;
        ctrl.writeReg  = rd;
        ctrl.muxSelect = (op == OP_LD);
        nextClass      = CLS_FETCH;
      end
      default: begin
        nextClass = CLS_FETCH;
      end
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer for the register-file/ALU/RAM datapath: fetches
// from a synchronous ROM, holds PC and IR, and walks each instruction
// through FETCH/DECODE/EXEC[/MEM][/WB]. All outputs are Moore-decoded.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              Z_BIT    = 0,
  parameter logic [PC_W-1:0] START_PC = '0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic [3:0]      signalBits,
  output logic [4:0]      readA,
  output logic [4:0]      readB,
  output logic [4:0]      writeReg,
  output logic            write,
  output logic [4:0]      functionsel,
  output logic            ALUcarry,
  output logic            RAMwrite,
  output logic            muxSelect,
  output logic [PC_W-1:0] pc
);

  state_t          state;
  state_t          stateNext;
  logic [PC_W-1:0] pcReg;
  logic [PC_W-1:0] pcNext;
  logic [31:0]     ir;
  logic [31:0]     irNext;

  ctrlWord_t       ctrl;
  nextClass_t      nextClass;
  logic [7:0]      tgt;
  logic [PC_W-1:0] tgtPc;
  logic            zeroFlag;
  logic            unusedStatus;

  instr_decoder uDecoder (
    .ir        (ir),
    .state     (state),
    .ctrl      (ctrl),
    .nextClass (nextClass),
    .tgt       (tgt)
  );

  assign tgtPc    = PC_W'(tgt);
  assign zeroFlag = signalBits[Z_BIT];
  // Only the zero flag steers branches; the other status bits are ignored.
  assign unusedStatus = ^signalBits;

  // State, PC and IR registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pcReg <= START_PC;
      ir    <= '0;
    end else begin
      state <= stateNext;
      pcReg <= pcNext;
      ir    <= irNext;
    end
  end

  // Next state, PC update and instruction latch.
  always_comb begin
    stateNext = state;
    pcNext    = pcReg;
    irNext    = ir;

    case (state)
      S_IDLE: begin
        if (start) begin
          pcNext    = START_PC;
          stateNext = S_FETCH;
        end
      end
      S_FETCH: begin
        stateNext = S_DECODE;
      end
      S_DECODE: begin
        // ROM data for the address shown in FETCH is valid now.
        irNext    = imem_rdata;
        pcNext    = pcReg + 1'b1;
        stateNext = S_EXEC;
      end
      S_EXEC: begin
        case (nextClass)
          CLS_WB:   stateNext = S_WB;
          CLS_MEM:  stateNext = S_MEM;
          CLS_BRZ: begin
            if (zeroFlag) pcNext = tgtPc;
            stateNext = S_FETCH;
          end
          CLS_JMP: begin
            pcNext    = tgtPc;
            stateNext = S_FETCH;
          end
          CLS_HALT: stateNext = S_IDLE;
          default:  stateNext = S_FETCH;
        endcase
      end
      S_MEM: begin
        stateNext = (nextClass == CLS_WB) ? S_WB : S_FETCH;
      end
      S_WB: begin
        stateNext = S_FETCH;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_EXEC) && (nextClass == CLS_HALT);
  // The ROM address is only presented while fetching; zero otherwise.
  assign imem_addr = (state == S_FETCH) ? pcReg : '0;
  assign pc        = pcReg;

  assign readA       = ctrl.readA;
  assign readB       = ctrl.readB;
  assign writeReg    = ctrl.writeReg;
  assign write       = ctrl.write;
  assign functionsel = ctrl.functionsel;
  assign ALUcarry    = ctrl.ALUcarry;
  assign RAMwrite    = ctrl.RAMwrite;
  assign muxSelect   = ctrl.muxSelect;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed program for the named scenarios,
// then a random ROM, each instruction checked against an instruction-level
// model of the execution rules.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [3:0]  signalBits;
  logic [4:0]  readA;
  logic [4:0]  readB;
  logic [4:0]  writeReg;
  logic        write;
  logic [4:0]  functionsel;
  logic        ALUcarry;
  logic        RAMwrite;
  logic        muxSelect;
  logic [7:0]  pc;

  logic [31:0] rom [256];
  logic [7:0]  mPc;
  int          checks = 0;
  int          errors = 0;

  datapath_sequencer #(.PC_W(8), .Z_BIT(0), .START_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .signalBits  (signalBits),
    .readA       (readA),
    .readB       (readB),
    .writeReg    (writeReg),
    .write       (write),
    .functionsel (functionsel),
    .ALUcarry    (ALUcarry),
    .RAMwrite    (RAMwrite),
    .muxSelect   (muxSelect),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM.
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All datapath controls at zero.
  task automatic quiet(input string tag);
    chk({tag, "_ctrl"}, {readA, readB, writeReg, functionsel, write, ALUcarry, RAMwrite, muxSelect}, 32'h0);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [4:0] fs, input logic cin,
                                      input logic [7:0] tgt);
    logic [31:0] w;
    w = {op, rd, ra, rb, fs, tgt};
    if (cin) w[7] = 1'b1;
    return w;
  endfunction

  // Run one instruction starting at the FETCH cycle (sampled at negedge).
  // Ends on the negedge of the next FETCH, or of IDLE after HALT.
  task automatic execOne(input logic [3:0] sig, input bit pokeStart, output bit halted);
    logic [31:0] ins;
    logic [3:0]  op;
    logic [4:0]  rd, ra, rb, fs;
    logic        cin, carry;
    logic [7:0]  tgt, incPc, nextPc;
    ins    = rom[mPc];
    op     = ins[31:28];
    rd     = ins[27:23];
    ra     = ins[22:18];
    rb     = ins[17:13];
    fs     = ins[12:8];
    cin    = ins[7];
    tgt    = ins[7:0];
    carry  = (op == 4'd0 || op == 4'd1 || op == 4'd2) ? cin : 1'b0;
    incPc  = mPc + 8'd1;
    nextPc = incPc;
    if (op == 4'd4 || (op == 4'd3 && sig[0])) nextPc = tgt;
    halted = (op == 4'd15);
    signalBits = sig;

    chk("fetch_addr", imem_addr, mPc);
    chk("fetch_busy", busy, 1);
    chk("fetch_done", done, 0);
    quiet("fetch");
    @(negedge clk);
    chk("decode_addr", imem_addr, 0);
    chk("decode_pc", pc, mPc);
    chk("decode_done", done, 0);
    quiet("decode");
    @(negedge clk);
    if (pokeStart) start = 1'b1;
    chk("exec_pc", pc, incPc);
    chk("exec_sel", {readA, readB, functionsel, ALUcarry}, {ra, rb, fs, carry});
    chk("exec_wr", {write, RAMwrite, writeReg, muxSelect}, 0);
    chk("exec_done", done, halted);
    chk("exec_busy", busy, 1);
    @(negedge clk);
    start = 1'b0;
    if (op == 4'd0) begin
      chk("alu_wb", {write, writeReg, muxSelect, RAMwrite}, {1'b1, rd, 1'b0, 1'b0});
      chk("alu_wb_sel", {readA, readB, functionsel, ALUcarry}, {ra, rb, fs, carry});
      chk("alu_wb_done", done, 0);
      @(negedge clk);
    end else if (op == 4'd1) begin
      chk("ld_mem", {write, RAMwrite, writeReg}, 0);
      chk("ld_mem_sel", {readA, readB, functionsel, ALUcarry}, {ra, rb, fs, carry});
      @(negedge clk);
      chk("ld_wb", {write, writeReg, muxSelect, RAMwrite}, {1'b1, rd, 1'b1, 1'b0});
      @(negedge clk);
    end else if (op == 4'd2) begin
      chk("st_mem", {write, RAMwrite, writeReg, muxSelect}, {1'b0, 1'b1, 5'd0, 1'b0});
      chk("st_mem_sel", {readA, readB, functionsel, ALUcarry}, {ra, rb, fs, carry});
      @(negedge clk);
    end
    mPc = nextPc;
    chk("retire_pc", pc, mPc);
    chk("retire_busy", busy, !halted);
    chk("retire_done", done, 0);
  endtask

  initial begin
    bit h;
    rst        = 1'b0;
    start      = 1'b0;
    signalBits = 4'h0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[8'h00] = mk(4'd0, 5'd3, 5'd1, 5'd2, 5'h01, 1'b1, 8'h00);
    rom[8'h01] = mk(4'd1, 5'd7, 5'd6, 5'd0, 5'h02, 1'b0, 8'h00);
    rom[8'h02] = mk(4'd2, 5'd0, 5'd4, 5'd5, 5'h02, 1'b1, 8'h00);
    rom[8'h03] = mk(4'd3, 5'd0, 5'd8, 5'd9, 5'h03, 1'b0, 8'h20);
    rom[8'h20] = mk(4'd3, 5'd0, 5'd8, 5'd9, 5'h03, 1'b0, 8'h40);
    rom[8'h21] = mk(4'd9, 5'd1, 5'd2, 5'd3, 5'h04, 1'b1, 8'h00);
    rom[8'h22] = mk(4'd4, 5'd0, 5'd0, 5'd0, 5'h00, 1'b0, 8'hFF);
    rom[8'hFF] = mk(4'd5, 5'd0, 5'd0, 5'd0, 5'h00, 1'b0, 8'h00);

    // Reset state.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", pc, 0);
    quiet("rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Reset in the middle of an ALU write-back.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_addr", imem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wb", {write, writeReg}, {1'b1, 5'd3});
    #2 rst = 1'b0;
    #1;
    chk("midwb_write", write, 0);
    chk("midwb_busy", busy, 0);
    chk("midwb_pc", pc, 0);
    chk("midwb_addr", imem_addr, 0);
    quiet("midwb");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_addr", imem_addr, 0);
    mPc = 8'h00;

    // Directed program: ALU, LD, ST, BRZ taken/not, illegal op, JMP wrap, HALT.
    execOne(4'($urandom), 1'b0, h);
    execOne(4'($urandom), 1'b0, h);
    execOne(4'($urandom), 1'b0, h);
    execOne(4'b0001, 1'b0, h);
    chk("brz_taken_pc", mPc, 8'h20);
    execOne(4'b0000, 1'b0, h);
    execOne(4'b1110, 1'b1, h);
    rom[8'h00] = mk(4'd15, 5'd0, 5'd0, 5'd0, 5'h00, 1'b0, 8'h00);
    execOne(4'($urandom), 1'b0, h);
    execOne(4'($urandom), 1'b0, h);
    execOne(4'($urandom), 1'b0, h);
    chk("halt_seen", h, 1);
    @(negedge clk);
    chk("halt_idle_busy", busy, 0);

    // Random program, restarting after each HALT.
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    h = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (h) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mPc = 8'h00;
      end
      execOne(4'($urandom), bit'($urandom_range(0, 1)), h);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
